// File: rtl/feeder_ctrl.sv
// Feeding-wheel controller.
// Turns a dispense request into a motor command, counts portions from the wheel's
// revolution sensor, pauses while the hopper is empty, and latches a stall when the
// wheel stops turning.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   en_i           clock enable; all registers hold while low
//   req_i          start request, honoured in idle only
//   n_req_i        portions to dispense, latched with req_i, clamped to MaxPortions
//   abort_i        cancel the current job or clear a stall
//   revolution_i   wheel sensor, high during the second half of each revolution
//   remain_i       hopper non-empty sensor
//   x_o            motor run command
//   busy_o         controller not idle
//   done_o         one-enabled-cycle pulse on job completion
//   n_done_o       portions counted in the current or last job
//   empty_o        waiting for refill
//   stall_o        wheel stalled, latched until abort or reset
module feeder_ctrl #(
    parameter int unsigned MaxPortions = 15,
    parameter int unsigned Timeout     = 131072,
    localparam int unsigned CntW       = $clog2(MaxPortions + 1),
    localparam int unsigned TmrW       = $clog2(Timeout + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            req_i,
    input  logic [CntW-1:0] n_req_i,
    input  logic            abort_i,
    input  logic            revolution_i,
    input  logic            remain_i,
    output logic            x_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [CntW-1:0] n_done_o,
    output logic            empty_o,
    output logic            stall_o
);

    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxPortions);
    localparam logic [TmrW-1:0] TmrMax  = '1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(Timeout - 1);

    typedef enum logic [1:0] {StIdle, StRun, StWaitRefill, StStall} state_e;

    state_e          state_q, state_d;
    logic            rev_q;
    logic            armed_q, armed_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [CntW-1:0] target_q, target_d;
    logic [CntW-1:0] n_done_q, n_done_d;
    logic            done_q, done_d;

    logic            rise, fall;
    logic [CntW-1:0] n_done_inc;

    assign rise       = revolution_i & ~rev_q;
    assign fall       = ~revolution_i & rev_q;
    assign n_done_inc = n_done_q + CntW'(1);

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        tmr_d    = tmr_q;
        target_d = target_q;
        n_done_d = n_done_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (n_req_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = (n_req_i > MaxCnt) ? MaxCnt : n_req_i;
                        n_done_d = '0;
                        tmr_d    = '0;
                        armed_d  = 1'b0;
                        state_d  = remain_i ? StRun : StWaitRefill;
                    end
                end
            end
            StRun: begin
                if (tmr_q != TmrMax) tmr_d = tmr_q + TmrW'(1);
                // A portion only drops during the low phase if one was there at the fall.
                if (fall) begin
                    armed_d = remain_i;
                    if (!remain_i) state_d = StWaitRefill;
                end
                if (rise) begin
                    tmr_d = '0;
                    if (armed_q) begin
                        n_done_d = n_done_inc;
                        armed_d  = 1'b0;
                    end
                    // Completion wins over an empty hopper on the last portion.
                    if (armed_q && (n_done_inc == target_q)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (!remain_i) begin
                        state_d = StWaitRefill;
                    end
                end else if (tmr_q >= TmrLast) begin
                    state_d = StStall;
                end
            end
            StWaitRefill: begin
                if (remain_i) begin
                    tmr_d   = '0;
                    state_d = StRun;
                end
            end
            StStall: begin
            end
            default: state_d = StIdle;
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d  = StIdle;
            done_d   = 1'b0;
            n_done_d = n_done_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            rev_q    <= 1'b1;  // a sensor already high out of reset is not a rise
            armed_q  <= 1'b0;
            tmr_q    <= '0;
            target_q <= '0;
            n_done_q <= '0;
            done_q   <= 1'b0;
        end else if (en_i) begin
            state_q  <= state_d;
            rev_q    <= revolution_i;
            armed_q  <= armed_d;
            tmr_q    <= tmr_d;
            target_q <= target_d;
            n_done_q <= n_done_d;
            done_q   <= done_d;
        end
    end

    assign x_o      = (state_q == StRun);
    assign busy_o   = (state_q != StIdle);
    assign empty_o  = (state_q == StWaitRefill);
    assign stall_o  = (state_q == StStall);
    assign done_o   = done_q;
    assign n_done_o = n_done_q;

endmodule

// File: tb/tb_feeder_ctrl.sv
module tb_feeder_ctrl;

    localparam int Period = 64;
    localparam int Refill = 20;
    localparam int Cap    = 3;

    logic       clk = 1'b0;
    logic       rst_n, en, req, abort, revolution, remain;
    logic [3:0] n_req;
    logic       x, busy, done, empty, stall;
    logic [3:0] n_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Feeder plant state.
    int phase      = Period / 2;
    int portions   = Cap;
    int refill_cnt = 0;
    bit plant_hold = 1'b0;

    feeder_ctrl #(
        .MaxPortions(15),
        .Timeout    (128)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .req_i       (req),
        .n_req_i     (n_req),
        .abort_i     (abort),
        .revolution_i(revolution),
        .remain_i    (remain),
        .x_o         (x),
        .busy_o      (busy),
        .done_o      (done),
        .n_done_o    (n_done),
        .empty_o     (empty),
        .stall_o     (stall)
    );

    always #5 clk = ~clk;

    // Wheel turns while x is high; a portion leaves the hopper at each rise.
    always @(negedge clk) begin
        if (!plant_hold) begin
            if (x === 1'b1) begin
                phase = (phase + 1) % Period;
                if (phase == Period / 2 && portions > 0) portions--;
            end
            if (portions == 0) begin
                refill_cnt++;
                if (refill_cnt >= Refill) begin
                    portions   = Cap;
                    refill_cnt = 0;
                end
            end
            revolution = (phase >= Period / 2);
            remain     = (portions > 0);
        end
    end

    function automatic void plant_init(input int p);
        phase      = Period / 2;
        portions   = p;
        refill_cnt = 0;
        revolution = 1'b1;
        remain     = (p > 0);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n      = 1'b0;
        en         = 1'b1;
        req        = 1'b0;
        abort      = 1'b0;
        n_req      = '0;
        plant_hold = 1'b0;
        plant_init(Cap);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_req(input int n);
        @(negedge clk);
        req   = 1'b1;
        n_req = 4'(n);
        @(negedge clk);
        req = 1'b0;
    endtask

    // Runs until idle or the budget expires, tallying done pulses and empty episodes.
    task automatic run_job(input int budget, output int cycles, output int dones,
                           output int empties, output int steps_bad);
        bit         prev_empty;
        logic [3:0] prev_nd;
        prev_empty = 1'b0;
        prev_nd    = n_done;
        cycles     = 0;
        dones      = 0;
        empties    = 0;
        steps_bad  = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) dones++;
            if (empty === 1'b1 && !prev_empty) empties++;
            prev_empty = (empty === 1'b1);
            if (n_done !== prev_nd && int'(n_done) != int'(prev_nd) + 1) steps_bad++;
            prev_nd = n_done;
            if (busy === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({x, busy, done, empty, stall, n_done} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {x, busy, done, empty, stall, n_done});
        end
    endtask

    task automatic test_two_portions();
        int c, d, e, s;
        do_reset();
        issue_req(2);
        tests_run++;
        if (x !== 1'b1) begin
            tests_failed++;
            $display("FAIL t1_x_next_cycle: got %b want 1", x);
        end
        run_job(1000, c, d, e, s);
        tests_run++;
        if (busy !== 1'b0 || n_done !== 4'd2) begin
            tests_failed++;
            $display("FAIL t1_finish: busy %b n_done %0d want 0 and 2", busy, n_done);
        end
        tests_run++;
        if (s != 0) begin
            tests_failed++;
            $display("FAIL t1_count_steps: got %0d bad steps want 0", s);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (d != 1 || done !== 1'b0 || x !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_done_pulse: pulses %0d done %b x %b want 1 0 0", d, done, x);
        end
        tests_run++;
        if (portions != 1) begin
            tests_failed++;
            $display("FAIL t1_plant_left: got %0d want 1", portions);
        end
    endtask

    task automatic test_refill();
        int c, d, e, s;
        do_reset();
        issue_req(5);
        run_job(2000, c, d, e, s);
        tests_run++;
        if (e != 1 || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_empty_episodes: got %0d (empty %b) want 1 (0)", e, empty);
        end
        tests_run++;
        if (n_done !== 4'd5 || d != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_finish: n_done %0d done pulses %0d busy %b want 5 1 0",
                     n_done, d, busy);
        end
    endtask

    task automatic test_stall();
        int xc;
        bit seen;
        do_reset();
        @(negedge clk);
        #1;
        plant_hold = 1'b1;
        revolution = 1'b1;
        remain     = 1'b1;
        issue_req(3);
        xc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (stall === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (x === 1'b1) xc++;
            @(negedge clk);
        end
        tests_run++;
        if (!seen || xc != 128 || x !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_stall_time: seen %b run cycles %0d x %b want 1 128 0", seen, xc, x);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (stall !== 1'b1 || x !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_stall_latched: stall %b x %b want 1 0", stall, x);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (stall !== 1'b0 || busy !== 1'b0 || seen) begin
            tests_failed++;
            $display("FAIL t3_abort: stall %b busy %b done_seen %b want 0 0 0", stall, busy, seen);
        end
        plant_hold = 1'b0;
    endtask

    task automatic test_zero_req();
        do_reset();
        issue_req(0);
        tests_run++;
        if (done !== 1'b1 || x !== 1'b0 || busy !== 1'b0 || n_done !== 4'd0) begin
            tests_failed++;
            $display("FAIL t4_zero_done: done %b x %b busy %b n_done %0d want 1 0 0 0",
                     done, x, busy, n_done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || x !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_zero_pulse_end: done %b x %b want 0 0", done, x);
        end
    endtask

    task automatic test_enable_and_async_reset();
        logic [8:0] snap;
        int         bad;
        bit         got;
        do_reset();
        issue_req(4);
        repeat (40) @(negedge clk);
        #1;
        plant_hold = 1'b1;
        en         = 1'b0;
        snap       = {x, busy, done, empty, stall, n_done};
        bad        = 0;
        repeat (200) begin
            @(negedge clk);
            if ({x, busy, done, empty, stall, n_done} !== snap) bad++;
        end
        tests_run++;
        if (bad != 0 || snap[8] !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_frozen: changes %0d x_at_freeze %b want 0 1", bad, snap[8]);
        end
        #1;
        en         = 1'b1;
        plant_hold = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || x !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_no_stall: stall %b x %b want 0 1", stall, x);
        end
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_done === 4'd1) begin
                got = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL t5_first_portion: n_done %0d want 1 within 200 cycles", n_done);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (x !== 1'b0 || n_done !== 4'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_async_reset: x %b n_done %0d busy %b want 0 0 0", x, n_done, busy);
        end
        @(negedge clk);
        #1;
        plant_init(Cap);
        rst_n = 1'b1;
    endtask

    task automatic test_abort_refill_and_busy_req();
        int c, d, e, s;
        bit got;
        do_reset();
        issue_req(5);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (empty === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!got || n_done !== 4'd3) begin
            tests_failed++;
            $display("FAIL t6_reach_empty: seen %b n_done %0d want 1 3", got, n_done);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || empty !== 1'b0 || n_done !== 4'd3 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_abort_refill: busy %b empty %b n_done %0d done %b want 0 0 3 0",
                     busy, empty, n_done, done);
        end
        #1;
        plant_init(Cap);
        issue_req(4);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (n_done === 4'd1) begin
                got = 1'b1;
                break;
            end
        end
        req   = 1'b1;
        n_req = 4'd2;
        @(negedge clk);
        req = 1'b0;
        tests_run++;
        if (!got || n_done !== 4'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6_busy_req_ignored: n_done %0d busy %b want 1 1", n_done, busy);
        end
        run_job(2000, c, d, e, s);
        tests_run++;
        if (n_done !== 4'd4 || d != 1) begin
            tests_failed++;
            $display("FAIL t6_job_target: n_done %0d pulses %0d want 4 1", n_done, d);
        end
    endtask

    // Back-to-back random jobs against a hopper-level model of drops and refills.
    task automatic test_random_jobs();
        int c, d, e, s;
        int p, n, rem, eps;
        do_reset();
        for (int j = 0; j < 8; j++) begin
            p   = int'($urandom_range(1, Cap));
            n   = int'($urandom_range(1, 15));
            rem = p;
            eps = 0;
            for (int i = 0; i < n; i++) begin
                if (rem == 0) begin
                    eps++;
                    rem = Cap;
                end
                rem--;
            end
            @(negedge clk);
            #1;
            plant_init(p);
            issue_req(n);
            run_job(3000, c, d, e, s);
            #1;
            tests_run++;
            if (busy !== 1'b0 || int'(n_done) != n || d != 1) begin
                tests_failed++;
                $display("FAIL rnd%0d_count: busy %b n_done %0d pulses %0d want 0 %0d 1",
                         j, busy, n_done, d, n);
            end
            tests_run++;
            if (e != eps || portions != rem) begin
                tests_failed++;
                $display("FAIL rnd%0d_hopper: empties %0d left %0d want %0d %0d (p=%0d n=%0d)",
                         j, e, portions, eps, rem, p, n);
            end
            tests_run++;
            if (s != 0) begin
                tests_failed++;
                $display("FAIL rnd%0d_steps: got %0d bad steps want 0", j, s);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        req        = 1'b0;
        abort      = 1'b0;
        n_req      = '0;
        revolution = 1'b1;
        remain     = 1'b1;
        test_reset();
        test_two_portions();
        test_refill();
        test_stall();
        test_zero_req();
        test_enable_and_async_reset();
        test_abort_refill_and_busy_req();
        test_random_jobs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
